// File: rtl/finger_game_ctrl.sv
// rtl/finger_game_ctrl.sv - finger-pattern game sequencer; optional streak bonus under STREAK_BONUS_EN
module finger_game_ctrl #(
  parameter int         TICKS_PER_ROUND = 50_000_000,
  parameter int         HOLD_CYCLES     = 1_000_000,
  parameter int         GAP_TICKS       = 25_000_000,
  parameter int         NUM_ROUNDS      = 20,
  parameter int         PASS_SCORE      = 12,
  parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] sw,
  output logic [7:0] score,
  output logic [3:0] pattern,
  output logic       C,
  output logic       res,
  output logic [7:0] round
);

  localparam int WIN_W  = (TICKS_PER_ROUND > 1) ? $clog2(TICKS_PER_ROUND) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int GAP_W  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  localparam logic [WIN_W-1:0]  WIN_LAST    = WIN_W'(TICKS_PER_ROUND - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST    = GAP_W'(GAP_TICKS - 1);
  localparam logic [7:0]        ROUNDS_LAST = 8'(NUM_ROUNDS - 1);
  localparam logic [8:0]        PASS_MIN    = 9'(PASS_SCORE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [7:0]        lfsr;
  logic [WIN_W-1:0]  win_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [GAP_W-1:0]  gap_cnt;

  logic       match;
  logic       hit;
  logic       timeout;
  logic       gap_end;
  logic [3:0] pick;
  logic [8:0] inc;
  logic [8:0] score_sum;
  logic [7:0] score_next;

`ifdef STREAK_BONUS_EN
  logic [1:0] streak;
  assign inc = (streak == 2'd3) ? 9'd2 : 9'd1;
`else
  assign inc = 9'd1;
`endif

  assign match      = (sw == pattern);
  assign hit        = (state == S_PLAY) && match && (hold_cnt == HOLD_LAST);
  assign timeout    = (state == S_PLAY) && !hit && (win_cnt == '0);
  assign gap_end    = (state == S_GAP) && (gap_cnt == '0);
  assign score_sum  = {1'b0, score} + inc;
  assign score_next = score_sum[8] ? 8'hFF : score_sum[7:0];

  // Never hand out an all-zero target: fall back to the high nibble, then a fixed one.
  always_comb begin
    pick = 4'b1000;
    if (lfsr[3:0] != 4'd0)
      pick = lfsr[3:0];
    else if (lfsr[7:4] != 4'd0)
      pick = lfsr[7:4];
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = S_LOAD;
      S_LOAD: state_next = S_PLAY;
      S_PLAY: if (hit || timeout) state_next = S_GAP;
      S_GAP:  if (gap_end) state_next = (round == ROUNDS_LAST) ? S_DONE : S_LOAD;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr     <= LFSR_SEED;
      score    <= 8'd0;
      pattern  <= 4'd0;
      C        <= 1'b0;
      res      <= 1'b0;
      round    <= 8'd0;
      win_cnt  <= '0;
      hold_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      case (state)
        S_IDLE: begin
          if (start) begin
            score <= 8'd0;
            round <= 8'd0;
          end
        end
        S_LOAD: begin
          pattern  <= pick;
          win_cnt  <= WIN_LAST;
          hold_cnt <= '0;
          C        <= 1'b1;
        end
        S_PLAY: begin
          // Counters may wrap on the exit cycle; they are reloaded before reuse.
          win_cnt  <= win_cnt - WIN_W'(1);
          hold_cnt <= match ? hold_cnt + HOLD_W'(1) : '0;
          if (hit || timeout) begin
            pattern <= 4'd0;
            gap_cnt <= GAP_LAST;
          end
          if (hit)
            score <= score_next;
        end
        S_GAP: begin
          gap_cnt <= gap_cnt - GAP_W'(1);
          if (gap_end)
            round <= round + 8'd1;
        end
        S_DONE: begin
          C   <= 1'b0;
          res <= ({1'b0, score} >= PASS_MIN);
        end
        default: ;
      endcase
    end
  end

`ifdef STREAK_BONUS_EN
  always_ff @(posedge clk) begin
    if (rst)
      streak <= 2'd0;
    else if (state == S_IDLE && start)
      streak <= 2'd0;
    else if (hit)
      streak <= (streak == 2'd3) ? 2'd3 : streak + 2'd1;
    else if (timeout)
      streak <= 2'd0;
  end
`endif

endmodule

// File: tb/tb_finger_game_ctrl.sv
// tb/tb_finger_game_ctrl.sv - randomized self-checking bench for finger_game_ctrl
module tb_finger_game_ctrl;

  localparam int         TICKS = 16;
  localparam int         HOLD  = 2;
  localparam int         GAP   = 4;
  localparam int         NR    = 4;
  localparam int         PASS  = 3;
  localparam logic [7:0] SEED  = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] sw = 4'd0;
  logic [7:0] score;
  logic [3:0] pattern;
  logic       C;
  logic       res;
  logic [7:0] round;

  finger_game_ctrl #(
    .TICKS_PER_ROUND(TICKS),
    .HOLD_CYCLES    (HOLD),
    .GAP_TICKS      (GAP),
    .NUM_ROUNDS     (NR),
    .PASS_SCORE     (PASS),
    .LFSR_SEED      (SEED)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sw     (sw),
    .score  (score),
    .pattern(pattern),
    .C      (C),
    .res    (res),
    .round  (round)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int ncyc     = 0;
  int exp_score;
  int exp_round;
  int exp_res;
  int streak;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, ncyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  // Reference LFSR: value held during the n-th cycle after reset release.
  function automatic logic [7:0] lfsr_at(input int n);
    logic [7:0] v;
    v = SEED;
    for (int i = 0; i < n; i++)
      v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    return v;
  endfunction

  function automatic logic [3:0] pick_of(input logic [7:0] v);
    if (v[3:0] != 4'd0) return v[3:0];
    if (v[7:4] != 4'd0) return v[7:4];
    return 4'b1000;
  endfunction

  function automatic logic [3:0] nomatch(input logic [3:0] p);
    logic [3:0] v;
    v = 4'($urandom_range(0, 15));
    if (v == p) v = p ^ 4'b0101;
    return v;
  endfunction

  task automatic credit_hit();
    int inc;
    inc = 1;
`ifdef STREAK_BONUS_EN
    if (streak == 3) inc = 2;
    if (streak < 3) streak++;
`endif
    exp_score = (exp_score + inc > 255) ? 255 : exp_score + inc;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ncyc = 0;
    exp_score = 0;
    exp_round = 0;
    exp_res = 0;
    streak = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_score"}, score, exp_score);
    check({tag, "_pattern"}, pattern, 0);
    check({tag, "_c"}, C, 0);
    check({tag, "_res"}, res, exp_res);
    check({tag, "_round"}, round, exp_round);
  endtask

  // Entered during the LOAD cycle; returns in the cycle after the round's last GAP edge.
  task automatic run_round(input bit hit, input int dly, input bit glitch, input bit pokes);
    logic [3:0] p;
    p = pick_of(lfsr_at(ncyc));
    tick();
    check("play_pattern", pattern, p);
    check("play_c", C, 1);
    if (hit) begin
      repeat (dly) begin
        sw = nomatch(p);
        start = pokes ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
      end
      start = 1'b0;
      if (glitch) begin
        sw = p;
        repeat (HOLD - 1) tick();
        sw = nomatch(p);
        tick();
        check("glitch_score", score, exp_score);
        check("glitch_pattern", pattern, p);
      end
      sw = p;
      repeat (HOLD - 1) tick();
      check("pre_hit_pattern", pattern, p);
      check("pre_hit_score", score, exp_score);
      tick();
      credit_hit();
      check("hit_pattern", pattern, 0);
      check("hit_score", score, exp_score);
    end else begin
      repeat (TICKS - 1) begin
        sw = nomatch(p);
        start = pokes ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
      end
      start = 1'b0;
      check("pre_to_pattern", pattern, p);
      sw = nomatch(p);
      tick();
      streak = 0;
      check("to_pattern", pattern, 0);
      check("to_score", score, exp_score);
    end
    sw = 4'd0;
    repeat (GAP - 1) tick();
    check("gap_round", round, exp_round);
    check("gap_pattern", pattern, 0);
    tick();
    exp_round++;
    check("round", round, exp_round);
  endtask

  // mode 0: all hits, 1: all timeouts, 2: glitch then hit, 3: random
  task automatic run_game(input int mode);
    bit h;
    bit g;
    int d;
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_score = 0;
    exp_round = 0;
    streak = 0;
    check("start_score", score, 0);
    check("start_round", round, 0);
    for (int r = 0; r < NR; r++) begin
      h = (mode == 0 || mode == 2) ? 1'b1 : (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      g = (mode == 2) ? 1'b1 : (mode == 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      d = (mode == 3) ? $urandom_range(0, 8) : 0;
      run_round(h, d, g, mode == 3);
    end
    check("done_cycle_c", C, 1);
    check("done_cycle_score", score, exp_score);
    tick();
    exp_res = (exp_score >= PASS) ? 1 : 0;
    check_all("done");
    tick();
    check_all("idle_after");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    check_all("reset");
    repeat (20) tick();
    check_all("idle20");

    run_game(0);
`ifdef STREAK_BONUS_EN
    check("hits_score", score, 5);
`else
    check("hits_score", score, 4);
`endif
    check("hits_res", res, 1);

    // Abort in the second round's PLAY after one hit.
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_score = 0;
    exp_round = 0;
    streak = 0;
    run_round(1'b1, 0, 1'b0, 1'b0);
    check("abort_pre_score", score, 1);
    tick();
    repeat (3) begin
      sw = nomatch(pattern);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ncyc = 0;
    exp_score = 0;
    exp_round = 0;
    exp_res = 0;
    streak = 0;
    sw = 4'd0;
    check_all("abort");

    run_game(0);
    run_game(1);
    check("miss_score", score, 0);
    check("miss_res", res, 0);
    run_game(2);
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 5)) tick();
      run_game(3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
